systolic_array: RTL and testbench
=================================

Name: systolic_array

Overview:
- 4x4 output-stationary systolic array of 8-bit multiply-accumulate processing elements (PEs) for the CNN datapath.
- Activation bytes enter from the left edge, one per row. Weight bytes enter from the top edge, one per column.
- Each PE multiplies the bytes passing through it, adds the product to its private accumulator, and forwards both operands to its neighbours one cycle later.
- All 16 accumulators are exposed continuously on a flat 128-bit result bus.

Parameters:
- None. Array size is fixed at 4x4; data, weight and accumulator width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low reset. Sampled on the rising clk edge; low clears all state.
- datain  input  32  four activation bytes. Lane k = bits [8k+7:8k] feeds row k (k = 0..3).
- weightin  input  32  four weight bytes. Lane k = bits [8k+7:8k] feeds column k (k = 0..3).
- macout  output  128  accumulator of PE(i,j) on bits [8(4i+j)+7 : 8(4i+j)]. i = row, j = column.

Behaviour:
- PE(i,j) state: a_reg (8b), b_reg (8b), acc (8b). All unsigned.
- PE(i,j) inputs:
  - a_in = datain lane i when j = 0, else a_reg of PE(i,j-1).
  - b_in = weightin lane j when i = 0, else b_reg of PE(i-1,j).
- On each rising edge with reset high:
  - acc <= acc + a_in*b_in.
  - a_reg <= a_in.
  - b_reg <= b_in.
- Arithmetic: the product is formed at 16 bits, and the sum is truncated to the low 8 bits (modulo 256 wrap). No saturation, no overflow flag.
- Propagation latency: operands on datain/weightin at edge t reach PE(i,j) at edge t+j for activations and t+i for weights.
  - The product lands in PE(i,j) acc at edge t + max(i,j) when the skewed operands align.
- macout is driven directly from the acc registers with no extra output register. Every acc update is visible right after the edge.
- Reset: when reset is low at a rising edge, every a_reg, b_reg and acc clears to 0, so macout = 0.
  - Inputs are ignored in that cycle.
  - Reset mid-computation discards all partial sums and in-flight operands.
- No clear-without-reset, no valid/ready handshake. Accumulation is unconditional every cycle.
  - Callers feed zeros to idle the array; zero operands add 0.
- Matrix multiply usage (C = A*B, A and B 4x4):
  - Present A[i][k] on datain lane i at cycle k+i. Present B[k][j] on weightin lane j at cycle k+j. Drive zeros otherwise.
  - After 10 edges from the first non-zero input, acc(i,j) = C[i][j] mod 256.
  - Holding an input lane at a non-zero value keeps accumulating.

Test Plan:
- Reset clear:
  - Stimulus: hold reset low 2 cycles with datain = weightin = 0xFFFFFFFF, then reset high with zero inputs.
  - Response: macout = 0 throughout and after.
- Single MAC:
  - Stimulus: after reset, one cycle with datain = 0x00000003 and weightin = 0x00000005, then zeros.
  - Response: macout[7:0] = 0x0F after that edge; all other bytes stay 0 on every following cycle.
- Horizontal propagation:
  - Stimulus: datain lane0 = 0x02 for one cycle, then zero. On the next cycle, weightin lane1 = 0x03.
  - Response: acc(0,1) = 0x06 on macout[15:8] after the second edge; acc(0,0) = 0.
- Accumulate and wrap:
  - Stimulus A: hold datain lane0 = 0x01 and weightin lane0 = 0x01 for 5 cycles. Response: macout[7:0] = 0x05.
  - Stimulus B: one cycle of 0x10*0x11. Response: acc = 0x10.
  - Stimulus C: one cycle of 0x10*0x10. Response: acc += 0 (wraps).
- Full skewed multiply:
  - Stimulus: A = all 0x01, B = all 0x02, fed with the skew above.
  - Response: after 10 edges, every macout byte = 0x08, and stays there while zeros are fed.
- Mid-run reset:
  - Stimulus: start the full multiply, assert reset low for 1 cycle at cycle 4, release, and restart the multiply.
  - Response: macout = 0 after the reset edge; the final result again equals 0x08 in every byte.

Source files
------------

// File: rtl/systolic_array.sv
// 4x4 output-stationary systolic array of unsigned 8-bit MAC processing elements.
// Activations flow left-to-right along rows and weights flow top-to-bottom along
// columns. Each PE keeps a private 8-bit accumulator that wraps modulo 256.
module systolic_array (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  datain,
  input  logic [31:0]  weightin,
  output logic [127:0] macout
);

  // Indexed [row][col][bit]; the packed layout places PE(i,j) at bits 8*(4i+j).
  logic [3:0][3:0][7:0]  a_q, a_d;
  logic [3:0][3:0][7:0]  b_q, b_d;
  logic [3:0][3:0][7:0]  acc_q, acc_d;
  logic [3:0][3:0][7:0]  a_in, b_in;
  logic [3:0][3:0][15:0] prod;

  // Route operands into each PE: edge lanes from the ports, others from neighbours.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < 4; i++) begin
      a_in[i][0] = datain[8*i +: 8];
      for (int j = 1; j < 4; j++) begin
        a_in[i][j] = a_q[i][j-1];
      end
    end
    for (int j = 0; j < 4; j++) begin
      b_in[0][j] = weightin[8*j +: 8];
      for (int i = 1; i < 4; i++) begin
        b_in[i][j] = b_q[i-1][j];
      end
    end
  end

  // Multiply-accumulate and operand forwarding for every PE.
  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_q;
    prod  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        prod[i][j]  = {8'h00, a_in[i][j]} * {8'h00, b_in[i][j]};
        // Only the low product byte can affect an 8-bit wrapping sum.
        acc_d[i][j] = acc_q[i][j] + prod[i][j][7:0];
      end
    end
  end

  // State registers with synchronous active-low clear of operands and sums.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign macout = acc_q;

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: the stimulus process queues the expected
// macout for every edge it drives; an independent monitor pops and compares.
module tb_systolic_array;

  logic         clk;
  logic         reset;
  logic [31:0]  datain;
  logic [31:0]  weightin;
  logic [127:0] macout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_q[$];
  bit           chk_q[$];
  string        name_q[$];

  localparam logic [127:0] AllEight = {16{8'h08}};

  systolic_array dut (
    .clk      (clk),
    .reset    (reset),
    .datain   (datain),
    .weightin (weightin),
    .macout   (macout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the rising edge and queue its expectation.
  task automatic step(input logic r, input logic [31:0] d, input logic [31:0] w,
                      input bit chk, input logic [127:0] exp, input string nm);
    @(negedge clk);
    reset    = r;
    datain   = d;
    weightin = w;
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    name_q.push_back(nm);
  endtask

  // Skewed feed for a constant matrix: lane k carries val during cycles k..k+3.
  function automatic logic [31:0] skew(input int c, input logic [7:0] val);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (c >= k && c <= k + 3) v[8*k +: 8] = val;
    end
    return v;
  endfunction

  // Monitor: macout is presented after every edge, so check one entry per edge.
  initial begin
    logic [127:0] e;
    bit           c;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        n = name_q.pop_front();
        if (c) begin
          n_tests++;
          if (macout !== e) begin
            n_fail++;
            $display("FAIL %s: macout=%h expected=%h", n, macout, e);
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b0;
    datain   = '0;
    weightin = '0;

    // Reset clear with all-ones inputs ignored.
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '0, "reset_hold0");
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '0, "reset_hold1");
    step(1'b1, 32'h0, 32'h0, 1'b1, '0, "reset_release0");
    step(1'b1, 32'h0, 32'h0, 1'b1, '0, "reset_release1");

    // Single MAC in PE(0,0); forwarded operands meet only zeros.
    step(1'b1, 32'h3, 32'h5, 1'b1, 128'h0F, "single_mac");
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 32'h0, 1'b1, 128'h0F, "single_hold");
    step(1'b0, 32'h0, 32'h0, 1'b1, '0, "single_reset");

    // Activation reaches PE(0,1) one edge later and meets weight lane 1.
    step(1'b1, 32'h2, 32'h0, 1'b1, '0, "horiz_first");
    step(1'b1, 32'h0, 32'h0000_0300, 1'b1, 128'h0600, "horiz_mac");
    step(1'b1, 32'h0, 32'h0, 1'b1, 128'h0600, "horiz_hold");
    step(1'b0, 32'h0, 32'h0, 1'b1, '0, "horiz_reset");

    // Accumulate 1*1 five times.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 32'h1, 32'h1, 1'b1, 128'(i), "accum");
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, '0, "accum_reset");
    // 0x10*0x11 = 0x110 -> 0x10; 0x10*0x10 = 0x100 -> +0; 0x10+0xFF wraps to 0x0F.
    step(1'b1, 32'h10, 32'h11, 1'b1, 128'h10, "wrap_prod_b");
    step(1'b1, 32'h10, 32'h10, 1'b1, 128'h10, "wrap_prod_c");
    step(1'b1, 32'hFF, 32'h01, 1'b1, 128'h0F, "wrap_sum");
    step(1'b0, 32'h0, 32'h0, 1'b1, '0, "wrap_reset");

    // Full skewed multiply: all-ones times all-twos gives 8 in every PE.
    for (int c = 0; c < 10; c++) begin
      if (c == 0)
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b1, 128'h02, "mm_first");
      else if (c == 8)
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b1, {8'h06, {15{8'h08}}}, "mm_edge9");
      else if (c == 9)
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b1, AllEight, "mm_done");
      else
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b0, '0, "mm_run");
    end
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 32'h0, 1'b1, AllEight, "mm_hold");

    // Mid-run reset discards partial sums and in-flight operands.
    step(1'b0, 32'h0, 32'h0, 1'b1, '0, "mid_pre_reset");
    for (int c = 0; c < 4; c++) begin
      step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b0, '0, "mid_run");
    end
    step(1'b0, skew(4, 8'h01), skew(4, 8'h02), 1'b1, '0, "mid_reset");
    for (int c = 0; c < 10; c++) begin
      if (c == 0)
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b1, 128'h02, "mid_restart");
      else if (c == 9)
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b1, AllEight, "mid_done");
      else
        step(1'b1, skew(c, 8'h01), skew(c, 8'h02), 1'b0, '0, "mid_run2");
    end
    for (int i = 0; i < 2; i++) step(1'b1, 32'h0, 32'h0, 1'b1, AllEight, "mid_hold");

    // Drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
